// File: rtl/i2c_cmd_serializer.sv
// i2c_cmd_serializer: turns register-level I2C commands into the byte stream
// consumed by axis_i2c_top (ADDR={dev,rw}, REG, and DATA for writes only).
// Optional macro I2C_CMD_FIFO_EN: when defined, commands wait in a
// FIFO_DEPTH-entry queue; otherwise a single holding register is used.
module i2c_cmd_serializer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [6:0]           cmd_dev_addr_i,
  input  logic                 cmd_rw_i,
  input  logic [7:0]           cmd_reg_addr_i,
  input  logic [7:0]           cmd_data_i,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] cmd_count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    REG  = 2'd2,
    DATA = 2'd3
  } state_t;

  // Packed command: [23:17] device, [16] rw, [15:8] register, [7:0] data.
  // Keeping {dev,rw} in the top byte makes the ADDR byte a plain slice.
  logic [23:0]          cmd_in;
  logic [23:0]          cmd_head;
  logic                 cmd_avail;
  logic                 push;
  logic                 pop;
  logic                 done;
  logic                 ready_en_reg;
  state_t               state_reg, state_next;
  logic [23:0]          work_reg, work_next;
  logic [CNT_WIDTH-1:0] cnt_reg;

  assign cmd_in = {cmd_dev_addr_i, cmd_rw_i, cmd_reg_addr_i, cmd_data_i};
  assign push   = cmd_valid_i && cmd_ready_o;

  // Holds cmd_ready_o low through reset and raises it on the first edge after release.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) ready_en_reg <= 1'b0;
    else          ready_en_reg <= 1'b1;
  end

`ifdef I2C_CMD_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  // Small queue read combinationally so a finishing command can be replaced
  // by the next one on the same edge without a bubble.
  logic [23:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic          full_reg;

  // Occupancy update; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count_reg;
    if (push && !pop)      count_next = count_reg + (AW+1)'(1);
    else if (!push && pop) count_next = count_reg - (AW+1)'(1);
  end

  // Queue pointers, occupancy and the registered full flag.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == (AW+1)'(FIFO_DEPTH));
    end
  end

  // Queue storage; contents need no reset because occupancy is reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg] <= cmd_in;
  end

  assign cmd_avail   = (count_reg != '0);
  assign cmd_head    = mem[rd_ptr_reg];
  assign cmd_ready_o = ready_en_reg && !full_reg;
`else
  // The queue depth only matters when the FIFO is built.
  localparam int unused_depth = FIFO_DEPTH;

  logic [23:0] hold_reg;
  logic        hold_full_reg;

  // Single holding register: filled on accept, emptied when the FSM loads it.
  // Push and pop never coincide because ready requires it to be empty.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
    end else if (push) begin
      hold_reg      <= cmd_in;
      hold_full_reg <= 1'b1;
    end else if (pop) begin
      hold_full_reg <= 1'b0;
    end
  end

  assign cmd_avail   = hold_full_reg;
  assign cmd_head    = hold_reg;
  assign cmd_ready_o = ready_en_reg && !hold_full_reg;
`endif

  // FSM state, working command and completed-command counter.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      work_reg  <= work_next;
      if (done) cnt_reg <= cnt_reg + CNT_WIDTH'(1);
    end
  end

  // Next-state logic: advance one byte per handshake, chain the next command on completion.
  always_comb begin
    state_next = state_reg;
    work_next  = work_reg;
    pop        = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: if (cmd_avail) begin
        pop        = 1'b1;
        work_next  = cmd_head;
        state_next = ADDR;
      end
      ADDR: if (m_axis_tready) state_next = REG;
      REG:  if (m_axis_tready) begin
        if (work_reg[16]) done = 1'b1;
        else              state_next = DATA;
      end
      DATA: if (m_axis_tready) done = 1'b1;
      default: state_next = IDLE;
    endcase
    if (done) begin
      if (cmd_avail) begin
        pop        = 1'b1;
        work_next  = cmd_head;
        state_next = ADDR;
      end else begin
        state_next = IDLE;
      end
    end
  end

  // Byte selection; valid comes from state only so it never depends on tready.
  always_comb begin
    m_axis_tdata = 8'h00;
    case (state_reg)
      ADDR:    m_axis_tdata = work_reg[23:16];
      REG:     m_axis_tdata = work_reg[15:8];
      DATA:    m_axis_tdata = work_reg[7:0];
      default: m_axis_tdata = 8'h00;
    endcase
  end

  assign m_axis_tvalid = (state_reg != IDLE);
  assign busy_o        = (state_reg != IDLE) || cmd_avail;
  assign cmd_count_o   = cnt_reg;

endmodule

// File: tb/tb_i2c_cmd_serializer.sv
// Testbench for i2c_cmd_serializer: directed steps plus a randomized phase,
// checked against a byte-queue reference model of the command stream.
module tb_i2c_cmd_serializer;

  localparam int TB_CNT_W = 4;
`ifdef I2C_CMD_FIFO_EN
  localparam int QN = 5;
`else
  localparam int QN = 2;
`endif

  logic                clk_i = 1'b0;
  logic                arstn_i = 1'b0;
  logic                cmd_valid_i = 1'b0;
  logic                cmd_ready_o;
  logic [6:0]          cmd_dev_addr_i = '0;
  logic                cmd_rw_i = 1'b0;
  logic [7:0]          cmd_reg_addr_i = '0;
  logic [7:0]          cmd_data_i = '0;
  logic [7:0]          m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tready = 1'b0;
  logic                busy_o;
  logic [TB_CNT_W-1:0] cmd_count_o;

  i2c_cmd_serializer #(.FIFO_DEPTH(4), .CNT_WIDTH(TB_CNT_W)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_dev_addr_i(cmd_dev_addr_i), .cmd_rw_i(cmd_rw_i),
    .cmd_reg_addr_i(cmd_reg_addr_i), .cmd_data_i(cmd_data_i),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .busy_o(busy_o), .cmd_count_o(cmd_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: expected bytes in order, bytes remaining per outstanding command.
  logic [7:0] exp_q[$];
  int         rem_q[$];
  int         exp_count = 0;
  int         hs_total  = 0;
  int         checks    = 0;
  int         errors    = 0;
  logic       accepted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge with inputs already driven.
  task automatic cycle();
    logic       acc, hs;
    logic [7:0] d;
    #1;
    acc = cmd_valid_i && cmd_ready_o;
    hs  = m_axis_tvalid && m_axis_tready;
    d   = m_axis_tdata;
    if (hs) begin
      check("byte_pending", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        check("byte", 32'(d), 32'(exp_q.pop_front()));
        hs_total++;
        rem_q[0] = rem_q[0] - 1;
        if (rem_q[0] == 0) begin
          void'(rem_q.pop_front());
          exp_count = (exp_count + 1) % (1 << TB_CNT_W);
          $display("[%0t] command done, count model %0d", $time, exp_count);
        end
      end
    end
    if (acc) begin
      accepted = 1'b1;
      exp_q.push_back({cmd_dev_addr_i, cmd_rw_i});
      exp_q.push_back(cmd_reg_addr_i);
      if (!cmd_rw_i) exp_q.push_back(cmd_data_i);
      rem_q.push_back(cmd_rw_i ? 2 : 3);
      $display("[%0t] accept dev=0x%02h rw=%0d reg=0x%02h data=0x%02h",
               $time, cmd_dev_addr_i, cmd_rw_i, cmd_reg_addr_i, cmd_data_i);
    end
    @(posedge clk_i);
    #1;
    check("cmd_count", 32'(cmd_count_o), 32'(exp_count));
    check("busy", 32'(busy_o), 32'(rem_q.size() != 0));
    @(negedge clk_i);
  endtask

  task automatic send_cmd(input logic [6:0] dev, input logic rw, input logic [7:0] ra, input logic [7:0] dat);
    cmd_dev_addr_i = dev; cmd_rw_i = rw; cmd_reg_addr_i = ra; cmd_data_i = dat;
    cmd_valid_i = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 40 && !accepted; i++) cycle();
    check("accept", 32'(accepted), 32'(1));
    cmd_valid_i = 1'b0;
  endtask

  task automatic drain();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 200 && rem_q.size() != 0; i++) cycle();
    check("drain_outstanding", 32'(rem_q.size()), 32'(0));
  endtask

  initial begin
    int hs_before;

    // Reset state
    #1;
    check("rst_tvalid", 32'(m_axis_tvalid), 32'(0));
    check("rst_tdata", 32'(m_axis_tdata), 32'(0));
    check("rst_ready", 32'(cmd_ready_o), 32'(0));
    check("rst_busy", 32'(busy_o), 32'(0));
    check("rst_count", 32'(cmd_count_o), 32'(0));
    repeat (3) @(negedge clk_i);
    arstn_i = 1'b1;
    #1 check("ready_before_edge", 32'(cmd_ready_o), 32'(0));
    @(posedge clk_i); #1;
    check("ready_after_edge", 32'(cmd_ready_o), 32'(1));
    @(negedge clk_i);

    // Single write with tready high: three consecutive bytes starting one cycle after acceptance
    m_axis_tready = 1'b1;
    send_cmd(7'h50, 1'b0, 8'h10, 8'hA5);
    check("lat_not_yet", 32'(m_axis_tvalid), 32'(0));
    cycle();
    check("lat_valid", 32'(m_axis_tvalid), 32'(1));
    check("lat_addr_byte", 32'(m_axis_tdata), 32'(8'hA0));
    hs_before = hs_total;
    repeat (3) cycle();
    check("write_bytes_consecutive", 32'(hs_total - hs_before), 32'(3));
    check("write_idle_after", 32'(m_axis_tvalid), 32'(0));

    // Single read: only two bytes, data field ignored
    send_cmd(7'h68, 1'b1, 8'h75, 8'h00);
    hs_before = hs_total;
    drain();
    check("read_byte_count", 32'(hs_total - hs_before), 32'(2));
    cycle();
    check("read_idle_after", 32'(m_axis_tvalid), 32'(0));

    // Backpressure during the REG byte
    m_axis_tready = 1'b0;
    send_cmd(7'h50, 1'b0, 8'h10, 8'hA5);
    cycle();
    m_axis_tready = 1'b1;
    cycle();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_tvalid", 32'(m_axis_tvalid), 32'(1));
      check("bp_tdata", 32'(m_axis_tdata), 32'(8'h10));
      cycle();
    end
    drain();

    // Saturation: one active command plus a full queue / holding register
    m_axis_tready = 1'b0;
    for (int i = 0; i < QN; i++)
      send_cmd(7'($urandom), 1'b0, 8'($urandom), 8'($urandom));
    check("sat_ready_low", 32'(cmd_ready_o), 32'(0));
    cmd_valid_i = 1'b1;
    accepted = 1'b0;
    repeat (3) cycle();
    check("sat_no_accept", 32'(accepted), 32'(0));
    cmd_valid_i = 1'b0;
    m_axis_tready = 1'b1;
    hs_before = hs_total;
    repeat (QN * 3) cycle();
    check("sat_no_gaps", 32'(hs_total - hs_before), 32'(QN * 3));
    check("sat_drained", 32'(rem_q.size()), 32'(0));

    // Reset during the DATA byte
    m_axis_tready = 1'b0;
    send_cmd(7'h2A, 1'b0, 8'h33, 8'h44);
    cycle();
    m_axis_tready = 1'b1;
    cycle(); cycle();
    m_axis_tready = 1'b0;
    check("pre_rst_data", 32'(m_axis_tdata), 32'(8'h44));
    arstn_i = 1'b0;
    #1;
    check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'(0));
    check("mid_rst_count", 32'(cmd_count_o), 32'(0));
    check("mid_rst_busy", 32'(busy_o), 32'(0));
    check("mid_rst_ready", 32'(cmd_ready_o), 32'(0));
    exp_q.delete(); rem_q.delete(); exp_count = 0;
    @(negedge clk_i);
    cycle();
    arstn_i = 1'b1;
    cycle();

    // Fresh writes after reset; 17 of them wrap the 4-bit counter to 1
    m_axis_tready = 1'b1;
    for (int i = 0; i < 17; i++)
      send_cmd(7'($urandom), 1'b0, 8'($urandom), 8'($urandom));
    drain();
    check("wrap_count", 32'(cmd_count_o), 32'(1));

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      m_axis_tready = ($urandom_range(0, 3) != 0);
      if (!cmd_valid_i || accepted) begin
        cmd_valid_i = ($urandom_range(0, 1) == 1);
        cmd_dev_addr_i = 7'($urandom); cmd_rw_i = 1'($urandom);
        cmd_reg_addr_i = 8'($urandom); cmd_data_i = 8'($urandom);
        accepted = 1'b0;
      end
      cycle();
    end
    cmd_valid_i = 1'b0;
    drain();
    check("final_queue_empty", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
